// File: rtl/fft_spectrum_sink.sv
// Receives the FFT result stream, stores |re|+|im| per bin in a readable buffer,
// tracks the per-frame peak bin and reports malformed or dropped frames.
module fft_spectrum_sink #(
   parameter int NPOINT  = 256,
   parameter int IDX_W   = 8,
   parameter bit SKIP_DC = 1'b1
) (
   input  logic             fft_clk,
   input  logic             rst_n,
   input  logic             s_axi4s_tvalid,
   input  logic [31:0]      s_axi4s_tdata,
   input  logic [IDX_W-1:0] s_axi4s_tuser,
   input  logic             s_axi4s_tlast,
   input  logic             hold,
   input  logic             rd_en,
   input  logic [IDX_W-1:0] rd_addr,
   output logic [16:0]      rd_data,
   output logic             frame_done,
   output logic [IDX_W-1:0] peak_bin,
   output logic [16:0]      peak_mag,
   output logic             frame_err,
   output logic [7:0]       drop_cnt
);
   localparam int DATA_W = 16;
   localparam int MAG_W  = DATA_W + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPOINT - 1);

   typedef enum logic [1:0] {IDLE, CAPTURE, DROP} state_t;

   // |-32768| = 32768 fits because the result is unsigned.
   function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] x);
      logic [DATA_W-1:0] u;
      u = x;
      return x[DATA_W-1] ? (~u + 1'b1) : u;
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

   state_t                   state;
   logic [IDX_W-1:0]         exp_idx;
   logic signed [DATA_W-1:0] re_p0, im_p0;
   logic                     idx_end, accept;

   logic                     vld_p1, first_p1, good_p1;
   logic [IDX_W-1:0]         idx_p1;
   logic [DATA_W-1:0]        are_p1, aim_p1;

   logic [MAG_W-1:0]         mag_p1, base_mag, next_mag, run_mag_p2;
   logic [IDX_W-1:0]         base_bin, next_bin, run_bin_p2;
   logic                     upd;

   logic [MAG_W-1:0]         mem [NPOINT];

   assign re_p0   = s_axi4s_tdata[15:0];
   assign im_p0   = s_axi4s_tdata[31:16];
   assign idx_end = (s_axi4s_tuser == LAST_IDX);

   always_comb begin
      accept = 1'b0;
      if (s_axi4s_tvalid) begin
         if (state == IDLE)
            accept = (s_axi4s_tuser == '0) && !hold;
         else if (state == CAPTURE)
            accept = (s_axi4s_tuser == exp_idx);
      end
   end

   // Stage 1: frame tracking and absolute values
   always_ff @(posedge fft_clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         exp_idx   <= '0;
         vld_p1    <= 1'b0;
         first_p1  <= 1'b0;
         good_p1   <= 1'b0;
         frame_err <= 1'b0;
         drop_cnt  <= '0;
      end else begin
         vld_p1    <= accept;
         first_p1  <= accept && (state == IDLE);
         good_p1   <= accept && s_axi4s_tlast && idx_end;
         frame_err <= 1'b0;
         if (accept) begin
            exp_idx <= s_axi4s_tuser + 1'b1;
            if (s_axi4s_tlast || idx_end) begin
               state <= IDLE;
               if (!(s_axi4s_tlast && idx_end)) begin
                  frame_err <= 1'b1;
                  drop_cnt  <= sat_inc(drop_cnt);
               end
            end else begin
               state <= CAPTURE;
            end
         end else if (s_axi4s_tvalid) begin
            case (state)
               IDLE: begin
                  if (s_axi4s_tuser == '0) begin
                     state    <= DROP;
                     drop_cnt <= sat_inc(drop_cnt);
                  end
               end
               CAPTURE: begin
                  frame_err <= 1'b1;
                  drop_cnt  <= sat_inc(drop_cnt);
                  state     <= DROP;
               end
               DROP: begin
                  if (s_axi4s_tlast)
                     state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge fft_clk) begin
      idx_p1 <= s_axi4s_tuser;
      are_p1 <= abs_val(re_p0);
      aim_p1 <= abs_val(im_p0);
   end

   // Beat 0 restarts the running peak; strict compare keeps the lower bin on ties.
   always_comb begin
      mag_p1   = {1'b0, are_p1} + {1'b0, aim_p1};
      base_mag = first_p1 ? '0 : run_mag_p2;
      base_bin = first_p1 ? '0 : run_bin_p2;
      upd      = (mag_p1 > base_mag) && !(SKIP_DC && (idx_p1 == '0));
      next_mag = upd ? mag_p1 : base_mag;
      next_bin = upd ? idx_p1 : base_bin;
   end

   // Stage 2: magnitude into the buffer and the running peak
   always_ff @(posedge fft_clk) begin
      if (vld_p1) begin
         mem[idx_p1] <= mag_p1;
         run_mag_p2  <= next_mag;
         run_bin_p2  <= next_bin;
      end
   end

   always_ff @(posedge fft_clk) begin
      if (!rst_n) begin
         frame_done <= 1'b0;
         peak_bin   <= '0;
         peak_mag   <= '0;
      end else begin
         frame_done <= vld_p1 && good_p1;
         if (vld_p1 && good_p1) begin
            peak_bin <= next_bin;
            peak_mag <= next_mag;
         end
      end
   end

   // Read-first: a same-cycle write to rd_addr is not visible until the next read.
   always_ff @(posedge fft_clk) begin
      if (!rst_n)
         rd_data <= '0;
      else if (rd_en)
         rd_data <= mem[rd_addr];
   end

endmodule

// File: doc/fft_spectrum_sink.md
# fft_spectrum_sink

Receiving end of the FFT core's output stream. Accepts the 256-point result stream (complex bins with index on `tuser` and `tlast` on the final bin) and computes an |re|+|im| magnitude per bin. It stores magnitudes in a dual-port spectrum buffer for host readout, tracks the peak bin per frame, and reports malformed or dropped frames.

## Interface

**Parameters**
- `NPOINT`, default 256: bins per frame; must be a power of two.
- `IDX_W`, default 8: log2(`NPOINT`); width of index and address.
- `SKIP_DC`, default 1: when 1, bin 0 is stored but excluded from the peak search.

**Ports**
- `fft_clk`, in, 1: single clock.
- `rst_n`, in, 1: synchronous, active-low reset.
- `s_axi4s_tvalid`, in, 1: result beat valid. The FFT output has no backpressure, so every valid beat is consumed.
- `s_axi4s_tdata`, in, 32: [15:0] real, [31:16] imag, both signed two's complement.
- `s_axi4s_tuser`, in, `IDX_W`: bin index of the beat.
- `s_axi4s_tlast`, in, 1: last bin of the frame.
- `hold`, in, 1: host is reading; frames starting while high are dropped.
- `rd_en`, in, 1: buffer read strobe.
- `rd_addr`, in, `IDX_W`: bin to read.
- `rd_data`, out, 17: magnitude of `rd_addr`; valid 1 cycle after `rd_en`.
- `frame_done`, out, 1: 1-cycle pulse when a good frame is complete and its results are published.
- `peak_bin`, out, `IDX_W`: bin of the maximum magnitude in the last good frame.
- `peak_mag`, out, 17: that maximum magnitude.
- `frame_err`, out, 1: 1-cycle pulse when a frame is detected as malformed.
- `drop_cnt`, out, 8: saturating count of frames dropped because of `hold` or an error.

## Operation

**Magnitude**
- Stage 1 registers |re| and |im| as 16-bit unsigned; |−32768| = 32768.
- Stage 2 registers mag = |re| + |im| as 17-bit unsigned. No truncation, no overflow.

**State machine**
- **IDLE**: waits for a valid beat with `tuser`==0.
  - If `hold`==1 on that beat: go to DROP; `drop_cnt`++ (saturates at 255).
  - Otherwise: go to CAPTURE, set expected index to 1, clear the running peak, and process beat 0.
  - Valid beats with `tuser`≠0 are ignored silently. No error is reported, because this covers start-up mid-frame.
- **CAPTURE**: processes each valid beat (see "Capture, per valid beat" below).
  - `tvalid` low cycles (gaps) are allowed anywhere; the state is held.
  - A beat with `tuser`≠expected: `frame_err` pulse, `drop_cnt`++, go to DROP. The beat is not written.
  - `tlast`=1 with `tuser`≠`NPOINT`-1, or `tuser`==`NPOINT`-1 with `tlast`=0: `frame_err` pulse, `drop_cnt`++, go to IDLE. The beat is written but no results are published.
  - `tlast`=1 with `tuser`==`NPOINT`-1: the frame is good; go to IDLE.
- **DROP**: discards beats until a beat with `tlast`=1, then goes to IDLE. A frame is never counted twice.

**Capture, per valid beat**
- The magnitude is written to buffer[`tuser`] through the 2-stage pipeline.
- Peak update: strictly greater than the running maximum, so on a tie the lower bin index is kept.
- When `SKIP_DC`=1, bin 0 never updates the peak; the running peak starts at mag 0, bin 0.

**Readout and hold**
- Buffer read port: read-first. A same-address read and write in the same cycle returns the old contents.
- `hold` is sampled only at frame start. Raising it mid-frame does not abort the frame in progress.

## Timing

- Reset values:
  - `frame_done`=0, `frame_err`=0, `peak_bin`=0, `peak_mag`=0, `drop_cnt`=0, `rd_data`=0.
  - State = IDLE.
  - Buffer contents are not cleared.
- Reset mid-frame: the partial frame is abandoned and no pulse is emitted. Capture restarts at the next `tuser`==0 after reset is released.
- Latency, beat to buffer write: 2 cycles.
- Good-frame completion:
  - `frame_done` pulses 2 cycles after the good `tlast` beat.
  - `peak_bin` and `peak_mag` update in that same cycle and hold until the next `frame_done`.
- Latency, error detection: `frame_err` pulses 1 cycle after the offending beat.
- Back-to-back frames: a `tuser`==0 beat in the cycle right after `tlast` is accepted. The pipeline must not lose it.
- `rd_data` is registered and updates only on `rd_en`; otherwise it holds its value.

## Test plan

1. **Reset**: assert `rst_n`=0 mid-frame, release → all outputs 0, no pulses; the next full frame completes with `frame_done` 2 cycles after `tlast`.
2. **Peak detect**: frame with bin 37 = (re=1000, im=−500) and all other bins = 10 → `peak_bin`=37, `peak_mag`=1500. Reading `rd_addr`=37 returns 1500 one cycle later.
3. **Extremes and DC**:
   - Bin 5 = (−32768, −32768) → mag 65536 stored and reported as the peak.
   - Separate frame with `SKIP_DC`=1 and bin 0 = 20000, all other bins ≤100 → `peak_bin`≠0.
   - Tie between bins 9 and 200 → `peak_bin`=9.
4. **Malformed frames**:
   - Skip index 50 → `frame_err` 1 cycle later, `drop_cnt`=1, no `frame_done`.
   - Early `tlast` at index 100 → second `frame_err`, `drop_cnt`=2.
   - The following good frame → `frame_done`.
5. **Hold**: `hold`=1 at index 0 → whole frame ignored, buffer unchanged, `drop_cnt`+1. `hold` raised at index 128 of a frame already capturing → that frame completes normally.
6. **Streaming**: 3 back-to-back frames with random `tvalid` gaps → 3 `frame_done` pulses with correct peaks. Then 300 held frames → `drop_cnt` saturates at 255.
